// File: rtl/rc4_encryptor.sv
// rtl/rc4_encryptor.sv - single-stream RC4 encryptor with valid/ready byte streams
module rc4_encryptor #(
   parameter int MSG_LEN   = 32,
   parameter int KEY_BYTES = 3
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [8*KEY_BYTES-1:0] secret_key,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [7:0]             out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   done,
   output logic [7:0]             byte_count
);

   typedef enum logic [3:0] {
      IDLE, INIT, KSA_J, KSA_SWAP, PRGA_IN, PRGA_J, PRGA_SWAP, PRGA_OUT, DONE
   } state_t;

   state_t                 state, next_state;
   logic [7:0]             i, j;
   logic [7:0]             key_idx;
   logic [8*KEY_BYTES-1:0] key_reg;
   logic [7:0]             pt;
   logic [7:0]             s_mem [256];
   logic [7:0]             s_i, s_j, t_idx, s_t, key_byte;

   // S reads; the keystream byte is taken before the swap lands, so forward the swapped values
   always_comb begin
      s_i   = s_mem[i];
      s_j   = s_mem[j];
      t_idx = s_i + s_j;
      if (t_idx == i)
         s_t = s_j;
      else if (t_idx == j)
         s_t = s_i;
      else
         s_t = s_mem[t_idx];
   end

   // key byte for the current KSA step; key_idx tracks i mod KEY_BYTES, byte 0 is the MSB
   always_comb begin
      key_byte = 8'h00;
      for (int k = 0; k < KEY_BYTES; k++) begin
         if (key_idx == 8'(k))
            key_byte = key_reg[8*(KEY_BYTES-1-k) +: 8];
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // next-state decode
   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: if (start) next_state = INIT;
         INIT:       if (i == 8'hFF) next_state = KSA_J;
         KSA_J:      next_state = KSA_SWAP;
         KSA_SWAP:   next_state = (i == 8'hFF) ? PRGA_IN : KSA_J;
         PRGA_IN:    if (in_valid && in_ready) next_state = PRGA_J;
         PRGA_J:     next_state = PRGA_SWAP;
         PRGA_SWAP:  next_state = PRGA_OUT;
         PRGA_OUT: begin
            if (out_valid && out_ready)
               next_state = (byte_count == 8'(MSG_LEN-1)) ? DONE : PRGA_IN;
         end
         default:    next_state = IDLE;
      endcase
   end

   // S array updates; contents are left untouched by reset
   always_ff @(posedge clk) begin
      if (reset_n) begin
         case (state)
            INIT: s_mem[i] <= i;
            KSA_SWAP, PRGA_SWAP: begin
               s_mem[i] <= s_j;
               s_mem[j] <= s_i;
            end
            default: ;
         endcase
      end
   end

   // indices, key, plaintext latch, output stream and status flags
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         i          <= 8'h00;
         j          <= 8'h00;
         key_idx    <= 8'h00;
         key_reg    <= '0;
         pt         <= 8'h00;
         out_data   <= 8'h00;
         out_valid  <= 1'b0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         byte_count <= 8'h00;
      end else begin
         in_ready <= (next_state == PRGA_IN);
         busy     <= (next_state != IDLE) && (next_state != DONE);
         done     <= (next_state == DONE);
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  key_reg    <= secret_key;
                  i          <= 8'h00;
                  j          <= 8'h00;
                  key_idx    <= 8'h00;
                  byte_count <= 8'h00;
               end
            end
            INIT: i <= i + 8'd1;
            KSA_J: j <= j + s_i + key_byte;
            KSA_SWAP: begin
               i       <= i + 8'd1;
               key_idx <= (key_idx == 8'(KEY_BYTES-1)) ? 8'h00 : key_idx + 8'd1;
               if (i == 8'hFF)
                  j <= 8'h00;
            end
            PRGA_IN: begin
               if (in_valid && in_ready) begin
                  pt <= in_data;
                  i  <= i + 8'd1;
               end
            end
            PRGA_J: j <= j + s_i;
            PRGA_SWAP: begin
               out_data  <= pt ^ s_t;
               out_valid <= 1'b1;
            end
            PRGA_OUT: begin
               if (out_valid && out_ready) begin
                  out_valid  <= 1'b0;
                  byte_count <= byte_count + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_encryptor.sv
// tb/tb_rc4_encryptor.sv - directed self-checking bench for rc4_encryptor
module tb_rc4_encryptor;

   localparam int          MSG_LEN = 9;
   localparam logic [23:0] KEY     = 24'h4B6579;
   localparam logic [71:0] PT_VEC  = 72'h50_6C_61_69_6E_74_65_78_74;
   localparam logic [71:0] CT_VEC  = 72'hBB_F3_16_E8_D9_40_AF_0A_D3;

   logic        clk = 1'b0;
   logic        reset_n, start, in_valid, out_ready;
   logic [23:0] secret_key;
   logic [7:0]  in_data;
   logic        in_ready, out_valid, busy, done;
   logic [7:0]  out_data, byte_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          wait_n, lat_n, first_wait, first_lat;
   bit          ir_leak, first_leak;
   logic [7:0]  got [MSG_LEN];

   rc4_encryptor #(.MSG_LEN(MSG_LEN), .KEY_BYTES(3)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .secret_key (secret_key),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .byte_count (byte_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic do_start(input logic [23:0] key);
      secret_key = key;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] pt, input int stall, input logic [7:0] hold_exp,
                            output logic [7:0] ct);
      int n;
      ct      = 8'h00;
      ir_leak = 1'b0;
      n       = 0;
      while (in_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      wait_n = n;
      if (in_ready !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
         return;
      end
      in_data   = pt;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
      n = 0;
      while (out_valid !== 1'b1 && n < 16) begin
         if (in_ready !== 1'b0) ir_leak = 1'b1;
         @(negedge clk);
         n++;
      end
      lat_n = n;
      if (out_valid !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
         out_ready = 1'b1;
         return;
      end
      if (in_ready !== 1'b0) ir_leak = 1'b1;
      ct = out_data;
      for (int c = 0; c < stall; c++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== hold_exp || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: out_valid=%b out_data=%h in_ready=%b, required 1 %h 0",
                     c, out_valid, out_data, in_ready, hold_exp);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic send_range(input logic [71:0] src, input int first, input int last,
                             input int stall_idx, input logic [71:0] hold_src);
      logic [7:0] c;
      for (int b = first; b <= last; b++) begin
         send_byte(src[71-8*b -: 8], (b == stall_idx) ? 10 : 0, hold_src[71-8*b -: 8], c);
         got[b] = c;
         if (b == 0) begin
            first_wait = wait_n;
            first_lat  = lat_n;
            first_leak = ir_leak;
         end
      end
   endtask

   task automatic check_stream(input string name, input logic [71:0] exp_vec);
      for (int b = 0; b < MSG_LEN; b++) begin
         n_checks++;
         if (got[b] !== exp_vec[71-8*b -: 8]) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, required %h", name, b, got[b], exp_vec[71-8*b -: 8]);
         end
      end
   endtask

   task automatic check_zero_outputs(input string name);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          out_data !== 8'h00 || byte_count !== 8'h00) begin
         n_fail++;
         $display("FAIL %s: in_ready=%b out_valid=%b busy=%b done=%b out_data=%h byte_count=%h, required all 0",
                  name, in_ready, out_valid, busy, done, out_data, byte_count);
      end
   endtask

   task automatic check_done_state(input string name);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || byte_count !== 8'd9 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: done=%b busy=%b byte_count=%0d in_ready=%b out_valid=%b, required 1 0 9 0 0",
                  name, done, busy, byte_count, in_ready, out_valid);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      secret_key = 24'h0; in_data = 8'h00;
      repeat (2) @(negedge clk);
      check_zero_outputs("reset_state");
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check_zero_outputs("idle_after_reset");
   endtask

   task automatic test_known_vector();
      do_start(KEY);
      send_range(PT_VEC, 0, MSG_LEN-1, -1, CT_VEC);
      n_checks++;
      if (first_wait + 1 != 769) begin
         n_fail++;
         $display("FAIL in_ready_first_edge: E+%0d, required E+769", first_wait + 1);
      end
      n_checks++;
      if (first_lat + 1 != 3) begin
         n_fail++;
         $display("FAIL out_valid_latency: A+%0d, required A+3", first_lat + 1);
      end
      n_checks++;
      if (first_leak !== 1'b0) begin
         n_fail++;
         $display("FAIL in_ready_low_during_byte: saw in_ready=1, required 0");
      end
      check_stream("known_ct", CT_VEC);
      check_done_state("known_done");
      n_checks++;
      if (out_data !== 8'hD3) begin
         n_fail++;
         $display("FAIL done_holds_out_data: got %h, required d3", out_data);
      end
   endtask

   task automatic test_backpressure();
      do_start(KEY);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b1 || byte_count !== 8'h00) begin
         n_fail++;
         $display("FAIL restart_from_done: done=%b busy=%b byte_count=%0d, required 0 1 0",
                  done, busy, byte_count);
      end
      send_range(PT_VEC, 0, MSG_LEN-1, 2, CT_VEC);
      check_stream("backpressure_ct", CT_VEC);
      check_done_state("backpressure_done");
   endtask

   task automatic test_round_trip();
      do_start(KEY);
      send_range(CT_VEC, 0, MSG_LEN-1, -1, PT_VEC);
      check_stream("round_trip_pt", PT_VEC);
      check_done_state("round_trip_done");
   endtask

   task automatic test_reset_mid();
      do_start(KEY);
      repeat (300) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_in_ksa: busy=%b in_ready=%b, required 1 0", busy, in_ready);
      end
      reset_n = 1'b0;
      @(negedge clk);
      check_zero_outputs("reset_in_ksa");
      reset_n = 1'b1;
      repeat (900) @(negedge clk);
      check_zero_outputs("quiet_after_ksa_reset");
      do_start(KEY);
      send_range(PT_VEC, 0, MSG_LEN-1, -1, CT_VEC);
      check_stream("after_ksa_reset_ct", CT_VEC);
      do_start(KEY);
      send_range(PT_VEC, 0, 3, -1, CT_VEC);
      n_checks++;
      if (byte_count !== 8'd4 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL four_bytes_sent: byte_count=%0d in_ready=%b, required 4 1", byte_count, in_ready);
      end
      reset_n = 1'b0;
      @(negedge clk);
      check_zero_outputs("reset_in_prga");
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check_zero_outputs("quiet_after_prga_reset");
      do_start(KEY);
      send_range(PT_VEC, 0, MSG_LEN-1, -1, CT_VEC);
      check_stream("after_prga_reset_ct", CT_VEC);
      check_done_state("after_prga_reset_done");
   endtask

   task automatic test_control();
      do_start(KEY);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      repeat (100) @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
      n_checks++;
      if (byte_count !== 8'h00 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL in_valid_while_not_ready: byte_count=%0d out_valid=%b, required 0 0",
                  byte_count, out_valid);
      end
      send_range(PT_VEC, 0, 1, -1, CT_VEC);
      secret_key = 24'h123456;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || byte_count !== 8'd2) begin
         n_fail++;
         $display("FAIL start_ignored_in_prga: busy=%b byte_count=%0d, required 1 2", busy, byte_count);
      end
      send_range(PT_VEC, 2, MSG_LEN-1, -1, CT_VEC);
      check_stream("control_ct", CT_VEC);
      check_done_state("control_done");
   endtask

   initial begin
      test_reset();
      test_known_vector();
      test_backpressure();
      test_round_trip();
      test_reset_mid();
      test_control();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
